// File: rtl/pipe_adder_nzcv.sv
// Pipelined ADD/SUB/ADC/SBC with ARM NZCV flags. The carry chain is cut into
// STAGES slices, one register per slice, under a stall-all valid/ready pipe.
module pipe_adder_nzcv #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       res_nzcv,
    output logic [3:0]       nzcv_reg
);
    localparam int SW = WIDTH / STAGES;
    localparam int LS = STAGES - 1;

    // s_q[k] holds the sum for slices 0..k and still-unsummed A bits above.
    logic [STAGES-1:0][WIDTH-1:0] s_q, s_d, b_q, b_d;
    logic [STAGES-1:0]            vld_q, vld_d, c_q, c_d, setf_q, setf_d;
    logic [3:0]                   flag_q, flag_d, nzcv_q, nzcv_d;
    logic [STAGES:0]              vld_pipe;
    logic                         adv, accept, cin;
    logic [WIDTH-1:0]             b_eff, src_s, src_b, sum;
    logic                         src_c, src_f;
    logic [SW:0]                  sl;

    assign adv      = !vld_q[LS] || out_ready;
    assign accept   = in_valid && adv;
    assign vld_pipe = {vld_q, accept};
    assign b_eff    = op[0] ? ~b : b;
    // ADC/SBC take C from the flag register as it stands at acceptance
    assign cin      = op[1] ? nzcv_q[1] : op[0];

    always_comb begin
        s_d    = s_q;
        b_d    = b_q;
        c_d    = c_q;
        setf_d = setf_q;
        vld_d  = vld_q;
        flag_d = flag_q;
        nzcv_d = nzcv_q;
        src_s  = '0;
        src_b  = '0;
        src_c  = 1'b0;
        src_f  = 1'b0;
        sl     = '0;
        sum    = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                src_s = a;
                src_b = b_eff;
                src_c = cin;
                src_f = set_flags;
            end else begin
                src_s = s_q[(k == 0) ? 0 : k-1];
                src_b = b_q[(k == 0) ? 0 : k-1];
                src_c = c_q[(k == 0) ? 0 : k-1];
                src_f = setf_q[(k == 0) ? 0 : k-1];
            end
            sl  = {1'b0, src_s[k*SW +: SW]} + {1'b0, src_b[k*SW +: SW]} + (SW+1)'(src_c);
            sum = src_s;
            sum[k*SW +: SW] = sl[SW-1:0];
            if (adv) begin
                vld_d[k] = vld_pipe[k];
                if (vld_pipe[k]) begin
                    s_d[k]    = sum;
                    b_d[k]    = src_b;
                    c_d[k]    = sl[SW];
                    setf_d[k] = src_f;
                    if (k == LS)
                        flag_d = {sum[WIDTH-1], sum == '0, sl[SW],
                                  (src_s[WIDTH-1] == src_b[WIDTH-1]) &&
                                  (sum[WIDTH-1] != src_s[WIDTH-1])};
                end
            end
        end
        if (vld_q[LS] && out_ready && setf_q[LS])
            nzcv_d = flag_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            setf_q <= '0;
            vld_q  <= '0;
            flag_q <= '0;
            nzcv_q <= '0;
        end else begin
            s_q    <= s_d;
            b_q    <= b_d;
            c_q    <= c_d;
            setf_q <= setf_d;
            vld_q  <= vld_d;
            flag_q <= flag_d;
            nzcv_q <= nzcv_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[LS];
    assign result    = s_q[LS];
    assign res_nzcv  = flag_q;
    assign nzcv_reg  = nzcv_q;
endmodule
